run_ctrl: RTL
=============

# run_ctrl

Synthesizable start/halt sequencer on the processor side of the `start`/`halt` handshake. The test bench currently drives this protocol and preloads state by hierarchical writes; `run_ctrl` does the DUT-side work in hardware:
- sweeps data memory and the register file to their initial values;
- holds the PC in reset until `start` falls;
- gates execution and asserts a sticky `halt` when the decoder reports a halt instruction or a watchdog expires.

It sits in TopLevel between the external `start` pin and the PC, data memory, and register file write ports.

## Interface
- `DMEM_DEPTH`, 256: data memory words cleared during init.
- `NREG`, 8: register file entries initialised.
- `REG_INIT`, 8'h01: value written to registers 0 and 1; all other locations get 8'h00.
- `MAX_CYCLES`, 16'hFFFF: watchdog limit on RUN cycles.

- `CLK` in, 1: clock, rising edge.
- `Reset` in, 1: asynchronous, active-high.
- `start` in, 1: level. High requests init and hold. A falling edge after init launches the program.
- `halt_req` in, 1: decoder flag, high for the cycle a halt instruction executes.
- `init_we` in…out, 1: write strobe to data memory or register file during init (output).
- `init_sel` out, 1: 0 selects data memory, 1 selects register file.
- `init_addr` out, 8: init write address.
- `init_data` out, 8: init write data.
- `pc_rst` out, 1: holds PC at 0.
- `run_en` out, 1: enables PC advance and architectural writes.
- `halt` out, 1: done flag, sticky until next init.
- `timeout` out, 1: halt was caused by the watchdog.
- `cycle_count` out, 16: RUN cycles since last init.

## Operation
- State machine states: IDLE, CLEAR_MEM, CLEAR_REG, ARMED, RUN, HALTED.
- Reset (async) forces:
  - state IDLE;
  - `init_we`=0, `init_sel`=0, `init_addr`=0, `init_data`=0;
  - `pc_rst`=1, `run_en`=0, `halt`=0, `timeout`=0, `cycle_count`=0.
- IDLE: on `start`=1, go to CLEAR_MEM with `init_addr`=0. `start` is sampled on the clock.
- CLEAR_MEM:
  - Drive `init_we`=1, `init_sel`=0, `init_data`=0.
  - `init_addr` increments each cycle.
  - After address DMEM_DEPTH-1, go to CLEAR_REG with `init_addr`=0.
- CLEAR_REG:
  - Drive `init_we`=1, `init_sel`=1.
  - `init_data`=REG_INIT for addresses 0 and 1; 0 for all other addresses.
  - After address NREG-1, go to ARMED if `start`=1, else go to RUN.
- ARMED: `pc_rst`=1, `init_we`=0. When `start`=0, go to RUN.
- RUN:
  - `pc_rst`=0, `run_en`=1.
  - `cycle_count` increments each RUN cycle.
  - `halt_req`=1 goes to HALTED with `timeout`=0.
  - Otherwise, if `cycle_count`==MAX_CYCLES-1, go to HALTED with `timeout`=1.
  - `halt_req` and watchdog in the same cycle: the halt wins and `timeout`=0.
- HALTED:
  - `halt`=1, `run_en`=0, `pc_rst`=0 (the PC holds its value for inspection).
  - `cycle_count` is frozen.
  - `start`=1 goes to CLEAR_MEM.
- Entering CLEAR_MEM from any state clears `halt`, `timeout`, and `cycle_count`.
- `pc_rst`=1 in IDLE, CLEAR_MEM, CLEAR_REG, and ARMED.
- `run_en`=1 only in RUN.
- `start` rising in RUN aborts the program: go to CLEAR_MEM next cycle. `halt` is not asserted.
- `start` falling during CLEAR_MEM or CLEAR_REG does not shorten the sweep. RUN follows CLEAR_REG directly.
- `halt_req` outside RUN is ignored.
- Mid-operation `Reset` returns to IDLE immediately. No partial-sweep state persists.

## Timing
- All outputs are registered. They change only on the `CLK` rising edge, except for the async `Reset` forcing.
- Init sweep length is exactly DMEM_DEPTH+NREG cycles: 264 at defaults.
- First RUN cycle (`run_en`=1) is the cycle after ARMED samples `start`=0, or the cycle after the last CLEAR_REG write.
- `halt` rises one cycle after `halt_req` is sampled high. In that same edge, `run_en` falls.
- `cycle_count` equals the number of cycles `run_en` was high.

## Test plan
- Reset, then hold `start`=1 for 300 cycles: 256 data memory writes of 0 (addresses 0..255, `init_sel`=0), then 8 register writes (reg0=1, reg1=1, reg2..7=0), then ARMED with `pc_rst`=1.
- From ARMED, drop `start`, then pulse `halt_req` on the 10th RUN cycle: `halt`=1, `timeout`=0, `cycle_count`=10, `run_en`=0; state holds.
- MAX_CYCLES=20 with no `halt_req`: `halt`=1, `timeout`=1, `cycle_count`=20.
- Drop `start` at CLEAR_MEM address 100: the sweep completes all 264 writes, then goes directly to RUN.
- Raise `start` on RUN cycle 5: CLEAR_MEM next cycle, `halt` stays 0, `cycle_count`=0. Raise `start` while HALTED: `halt` and `cycle_count` clear and the sweep restarts.
- Assert `Reset` asynchronously mid-CLEAR_REG: outputs take reset values before the next edge. `halt_req`=1 in IDLE is ignored.

Source files
------------

// File: rtl/run_ctrl_if.sv
// Start/halt handshake and init write port between the external pin/decoder side and run_ctrl.
// master drives start/halt_req; slave (run_ctrl) drives the init port, PC/run gating and status.
interface run_ctrl_if;
  logic        start;
  logic        halt_req;
  logic        init_we;
  logic        init_sel;
  logic [7:0]  init_addr;
  logic [7:0]  init_data;
  logic        pc_rst;
  logic        run_en;
  logic        halt;
  logic        timeout;
  logic [15:0] cycle_count;

  modport master (
    output start, halt_req,
    input  init_we, init_sel, init_addr, init_data,
    input  pc_rst, run_en, halt, timeout, cycle_count
  );

  modport slave (
    input  start, halt_req,
    output init_we, init_sel, init_addr, init_data,
    output pc_rst, run_en, halt, timeout, cycle_count
  );
endinterface

// File: rtl/run_ctrl.sv
// Start/halt sequencer: clears dmem and regfile, holds PC until start falls, runs until halt or watchdog.
// All outputs registered (one-cycle response to start/halt_req); no backpressure, the sweep never stalls.
module run_ctrl #(
  parameter int          DMEM_DEPTH = 256,
  parameter int          NREG       = 8,
  parameter logic [7:0]  REG_INIT   = 8'h01,
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic     CLK,
  input  logic     Reset,
  run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR_MEM,
    CLEAR_REG,
    ARMED,
    RUN,
    HALTED
  } state_t;

  localparam logic [7:0] LAST_MEM = 8'(DMEM_DEPTH - 1);
  localparam logic [7:0] LAST_REG = 8'(NREG - 1);

  state_t      state_q, state_d;
  logic        init_we_q, init_we_d;
  logic        init_sel_q, init_sel_d;
  logic [7:0]  init_addr_q, init_addr_d;
  logic [7:0]  init_data_q, init_data_d;
  logic        pc_rst_q, pc_rst_d;
  logic        run_en_q, run_en_d;
  logic        halt_q, halt_d;
  logic        timeout_q, timeout_d;
  logic [15:0] cycle_count_q, cycle_count_d;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      init_we_q     <= 1'b0;
      init_sel_q    <= 1'b0;
      init_addr_q   <= 8'd0;
      init_data_q   <= 8'd0;
      pc_rst_q      <= 1'b1;
      run_en_q      <= 1'b0;
      halt_q        <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      init_we_q     <= init_we_d;
      init_sel_q    <= init_sel_d;
      init_addr_q   <= init_addr_d;
      init_data_q   <= init_data_d;
      pc_rst_q      <= pc_rst_d;
      run_en_q      <= run_en_d;
      halt_q        <= halt_d;
      timeout_q     <= timeout_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    init_addr_d   = init_addr_q;
    halt_d        = halt_q;
    timeout_d     = timeout_q;
    cycle_count_d = cycle_count_q;

    case (state_q)
      IDLE: begin
        if (bus.start) state_d = CLEAR_MEM;
      end
      CLEAR_MEM: begin
        if (init_addr_q == LAST_MEM) begin
          state_d     = CLEAR_REG;
          init_addr_d = 8'd0;
        end else begin
          init_addr_d = init_addr_q + 8'd1;
        end
      end
      CLEAR_REG: begin
        if (init_addr_q == LAST_REG) begin
          state_d     = bus.start ? ARMED : RUN;
          init_addr_d = 8'd0;
        end else begin
          init_addr_d = init_addr_q + 8'd1;
        end
      end
      ARMED: begin
        if (!bus.start) state_d = RUN;
      end
      RUN: begin
        cycle_count_d = cycle_count_q + 16'd1;
        // Abort beats halt, and a real halt beats the watchdog.
        if (bus.start) begin
          state_d = CLEAR_MEM;
        end else if (bus.halt_req) begin
          state_d   = HALTED;
          halt_d    = 1'b1;
          timeout_d = 1'b0;
        end else if (cycle_count_q == MAX_CYCLES - 16'd1) begin
          state_d   = HALTED;
          halt_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      HALTED: begin
        if (bus.start) state_d = CLEAR_MEM;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == CLEAR_MEM && state_q != CLEAR_MEM) begin
      init_addr_d   = 8'd0;
      halt_d        = 1'b0;
      timeout_d     = 1'b0;
      cycle_count_d = 16'd0;
    end

    // Outputs follow the state being entered so they are valid in that state's first cycle.
    init_we_d   = (state_d == CLEAR_MEM) || (state_d == CLEAR_REG);
    init_sel_d  = (state_d == CLEAR_REG);
    init_data_d = (state_d == CLEAR_REG && init_addr_d < 8'd2) ? REG_INIT : 8'd0;
    pc_rst_d    = (state_d == IDLE) || (state_d == CLEAR_MEM) ||
                  (state_d == CLEAR_REG) || (state_d == ARMED);
    run_en_d    = (state_d == RUN);
  end

  assign bus.init_we     = init_we_q;
  assign bus.init_sel    = init_sel_q;
  assign bus.init_addr   = init_addr_q;
  assign bus.init_data   = init_data_q;
  assign bus.pc_rst      = pc_rst_q;
  assign bus.run_en      = run_en_q;
  assign bus.halt        = halt_q;
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cycle_count_q;

endmodule
